// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the core ALU and the blocks that borrow it.
//   - ALU opcode encodings (4-bit ALUControl values)
//   - mul_state_t : state encoding of the multiply sequencer FSM
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b1100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1110;
    localparam logic [3:0] ALU_SRL  = 4'b1101;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_RUN  = 2'b01,
        MS_DONE = 2'b10
    } mul_state_t;

endpackage : alu_pkg

// File: rtl/alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// alu_mul_sequencer
// Computes MUL (low N_Bits of op_a*op_b, sign-agnostic) by borrowing the
// shared core ALU for one ADD per cycle in a shift-and-add loop.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   start, kill       : request (taken only in IDLE) / flush abort
//   op_a, op_b        : multiplicand / multiplier, latched on accepted start
//   ALUResult         : sum returned by the shared ALU
//   SrcA, SrcB        : ALU operands (accumulator, gated shifted multiplicand)
//   ALUControl        : ALU opcode, always ADD
//   alu_busy          : high in RUN, steers the core ALU input mux here
//   busy              : high in RUN or DONE
//   done              : one-cycle pulse when result becomes valid
//   result            : product, held until the next completed operation
// -----------------------------------------------------------------------------
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int N_Bits     = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              kill,
    input  logic [N_Bits-1:0] op_a,
    input  logic [N_Bits-1:0] op_b,
    input  logic [N_Bits-1:0] ALUResult,
    output logic [N_Bits-1:0] SrcA,
    output logic [N_Bits-1:0] SrcB,
    output logic [3:0]        ALUControl,
    output logic              alu_busy,
    output logic              busy,
    output logic              done,
    output logic [N_Bits-1:0] result
);

    localparam int               CNT_W    = (N_Bits > 1) ? $clog2(N_Bits) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_Bits - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mul_state_t        state_q,    state_d;
    logic [N_Bits-1:0] acc_q,      acc_d;
    logic [N_Bits-1:0] mcand_q,    mcand_d;
    logic [N_Bits-1:0] mplier_q,   mplier_d;
    logic [N_Bits-1:0] result_q,   result_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              alu_busy_q, alu_busy_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              last_step_s;

    // Decide whether the current RUN cycle is the final add.
    always_comb begin
        last_step_s = 1'b0;
        if (cnt_q == CNT_LAST) begin
            last_step_s = 1'b1;
        end else if (EARLY_EXIT && (mplier_q[N_Bits-1:1] == {(N_Bits-1){1'b0}})) begin
            // Remaining multiplier bits after this step are all zero, so
            // further adds would only contribute zeros.
            last_step_s = 1'b1;
        end else begin
            last_step_s = 1'b0;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        cnt_d    = cnt_q;

        case (state_q)
            MS_IDLE: begin
                // kill dominates a simultaneous start
                if (start && !kill) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = {N_Bits{1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = MS_RUN;
                end else begin
                    state_d  = MS_IDLE;
                end
            end
            MS_RUN: begin
                if (kill) begin
                    // Abort: result is left untouched so the previous product stays visible.
                    state_d = MS_IDLE;
                end else begin
                    acc_d    = ALUResult;
                    mcand_d  = {mcand_q[N_Bits-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[N_Bits-1:1]};
                    cnt_d    = cnt_q + CNT_ONE;
                    if (last_step_s) begin
                        result_d = ALUResult;
                        state_d  = MS_DONE;
                    end else begin
                        state_d  = MS_RUN;
                    end
                end
            end
            MS_DONE: begin
                state_d = MS_IDLE;
            end
            default: begin
                state_d = MS_IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state.
        alu_busy_d = (state_d == MS_RUN);
        busy_d     = (state_d == MS_RUN) || (state_d == MS_DONE);
        done_d     = (state_d == MS_DONE);
    end

    // State, datapath and status registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= MS_IDLE;
            acc_q      <= {N_Bits{1'b0}};
            mcand_q    <= {N_Bits{1'b0}};
            mplier_q   <= {N_Bits{1'b0}};
            result_q   <= {N_Bits{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            alu_busy_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            alu_busy_q <= alu_busy_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // ALU operand drive; zero outside RUN so the shared ALU sees quiet inputs.
    always_comb begin
        SrcA       = {N_Bits{1'b0}};
        SrcB       = {N_Bits{1'b0}};
        ALUControl = ALU_ADD;
        if (state_q == MS_RUN) begin
            SrcA = acc_q;
            if (mplier_q[0]) begin
                SrcB = mcand_q;
            end else begin
                SrcB = {N_Bits{1'b0}};
            end
        end else begin
            SrcA = {N_Bits{1'b0}};
            SrcB = {N_Bits{1'b0}};
        end
    end

    assign alu_busy = alu_busy_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;

endmodule : alu_mul_sequencer

// File: tb/tb_alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_sequencer
// Two sequencers (fixed latency and early exit), each wired to its own
// behavioural model of the shared ALU, driven by directed vectors.
// -----------------------------------------------------------------------------
module tb_alu_mul_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start0 = 1'b0, kill0 = 1'b0;
    logic [31:0] a0 = 32'h0, b0 = 32'h0;
    logic [31:0] srca0, srcb0, alures0, res0;
    logic [3:0]  ctrl0;
    logic        abusy0, busy0, done0;

    logic        start1 = 1'b0, kill1 = 1'b0;
    logic [31:0] a1 = 32'h0, b1 = 32'h0;
    logic [31:0] srca1, srcb1, alures1, res1;
    logic [3:0]  ctrl1;
    logic        abusy1, busy1, done1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
        case (c)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLT:  return {31'h0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'h0, a < b};
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $signed(a) >>> b[4:0];
            default:  return 32'h0;
        endcase
    endfunction

    assign alures0 = alu_f(srca0, srcb0, ctrl0);
    assign alures1 = alu_f(srca1, srcb1, ctrl1);

    alu_mul_sequencer #(.N_Bits(32), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .kill(kill0),
        .op_a(a0), .op_b(b0), .ALUResult(alures0),
        .SrcA(srca0), .SrcB(srcb0), .ALUControl(ctrl0),
        .alu_busy(abusy0), .busy(busy0), .done(done0), .result(res0)
    );

    alu_mul_sequencer #(.N_Bits(32), .EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .kill(kill1),
        .op_a(a1), .op_b(b1), .ALUResult(alures1),
        .SrcA(srca1), .SrcB(srcb1), .ALUControl(ctrl1),
        .alu_busy(abusy1), .busy(busy1), .done(done1), .result(res1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op; returns the cycle in which done rose (0 = never) and the
    // number of cycles alu_busy was high. Leaves the bench in the done cycle.
    task automatic do_mul(input bit which, input logic [31:0] a, input logic [31:0] b,
                          output int done_cyc, output int ab_cyc);
        if (which) begin
            start1 = 1'b1; a1 = a; b1 = b;
        end else begin
            start0 = 1'b1; a0 = a; b0 = b;
        end
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        done_cyc = 0;
        ab_cyc   = 0;
        for (int c = 1; c <= 40; c++) begin
            if ((which ? abusy1 : abusy0) === 1'b1) ab_cyc++;
            if ((which ? done1 : done0) === 1'b1) begin
                done_cyc = c;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int dc, ab, ndone, first_done;
        logic done_at [1:9];
        logic busy_at [1:9];

        // ---------------- reset state ----------------
        #1 rst = 1'b1;
        #2;
        check("rst_busy",     {31'h0, busy0},  32'h0);
        check("rst_alu_busy", {31'h0, abusy0}, 32'h0);
        check("rst_done",     {31'h0, done0},  32'h0);
        check("rst_result",   res0,            32'h0);
        check("rst_srca",     srca0,           32'h0);
        check("rst_srcb",     srcb0,           32'h0);
        check("rst_ctrl",     {28'h0, ctrl0},  32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ---------------- T1: fixed latency 7*6 ----------------
        do_mul(1'b0, 32'd7, 32'd6, dc, ab);
        check("t1_done_cycle",   dc,   32'd33);
        check("t1_alu_busy_cyc", ab,   32'd32);
        check("t1_result",       res0, 32'd42);
        check("t1_busy_in_done", {31'h0, busy0}, 32'h1);
        tick();
        check("t1_done_pulse",   {31'h0, done0}, 32'h0);
        check("t1_idle_busy",    {31'h0, busy0}, 32'h0);

        // ---------------- T2: wrap-around ----------------
        do_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, ab);
        check("t2_ff_result", res0, 32'h0000_0001);
        tick();
        do_mul(1'b0, 32'h8000_0000, 32'd2, dc, ab);
        check("t2_msb_result", res0, 32'h0);
        tick();
        do_mul(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, ab);
        check("t2_ee_full_cycle", dc,   32'd33);
        check("t2_ee_ff_result",  res1, 32'h0000_0001);
        tick();

        // ---------------- T3: early exit ----------------
        do_mul(1'b1, 32'd123, 32'd0, dc, ab);
        check("t3_b0_cycle",  dc,   32'd2);
        check("t3_b0_result", res1, 32'd0);
        tick();
        start1 = 1'b1; a1 = 32'd5; b1 = 32'd1;
        tick();
        start1 = 1'b0;
        check("t3_run_srca",  srca1,           32'd0);
        check("t3_run_srcb",  srcb1,           32'd5);
        check("t3_run_ctrl",  {28'h0, ctrl1},  32'h0);
        check("t3_run_abusy", {31'h0, abusy1}, 32'h1);
        tick();
        check("t3_b1_done",   {31'h0, done1},  32'h1);
        check("t3_b1_result", res1,            32'd5);
        check("t3_b1_abusy",  {31'h0, abusy1}, 32'h0);
        tick();
        do_mul(1'b1, 32'd5, 32'd3, dc, ab);
        check("t3_b3_cycle",  dc,   32'd3);
        check("t3_b3_result", res1, 32'd15);
        tick();

        // ---------------- T4: start while busy is ignored ----------------
        start0 = 1'b1; a0 = 32'd12; b0 = 32'd12;
        tick();                                  // cycle 1
        start0 = 1'b0;
        tick(); tick(); tick(); tick();          // cycle 5
        start0 = 1'b1; a0 = 32'd3; b0 = 32'd3;
        tick();                                  // cycle 6
        start0 = 1'b0;
        ndone = 0;
        first_done = 0;
        for (int c = 6; c <= 45; c++) begin
            if (done0 === 1'b1) begin
                ndone++;
                if (first_done == 0) first_done = c;
            end
            tick();
        end
        check("t4_done_count", ndone,      32'd1);
        check("t4_done_cycle", first_done, 32'd33);
        check("t4_result",     res0,       32'd144);

        // ---------------- T5: kill mid-run ----------------
        start0 = 1'b1; a0 = 32'd9; b0 = 32'd9;
        tick();                                  // cycle 1
        start0 = 1'b0;
        tick(); tick(); tick();                  // cycle 4
        kill0 = 1'b1;
        tick();                                  // cycle 5
        kill0 = 1'b0;
        check("t5_kill_busy",  {31'h0, busy0},  32'h0);
        check("t5_kill_abusy", {31'h0, abusy0}, 32'h0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done0 === 1'b1) ndone++;
            tick();
        end
        check("t5_no_done",      ndone, 32'd0);
        check("t5_result_held",  res0,  32'd144);
        start0 = 1'b1; kill0 = 1'b1; a0 = 32'd4; b0 = 32'd4;
        tick();
        start0 = 1'b0; kill0 = 1'b0;
        check("t5_kill_wins", {31'h0, busy0}, 32'h0);
        do_mul(1'b0, 32'd2, 32'd3, dc, ab);
        check("t5_new_cycle",  dc,   32'd33);
        check("t5_new_result", res0, 32'd6);
        tick();

        // ---------------- T6: async reset mid-run ----------------
        do_mul(1'b1, 32'd7, 32'hFFFF_FFFF, dc, ab);  // leaves res1 = 7*(-1)
        check("t6_pre_result", res1, 32'hFFFF_FFF9);
        tick();
        start1 = 1'b1; a1 = 32'd7; b1 = 32'hFFFF_FFFF;
        tick();                                  // cycle 1
        start1 = 1'b0;
        tick(); tick();                          // cycle 3, mid-RUN
        check("t6_running", {31'h0, abusy1}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_abusy", {31'h0, abusy1}, 32'h0);
        check("t6_async_busy",  {31'h0, busy1},  32'h0);
        check("t6_async_done",  {31'h0, done1},  32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_result_cleared", res1, 32'h0);

        // start held high: DONE, one IDLE cycle, then the next op
        start1 = 1'b1; a1 = 32'd5; b1 = 32'd3;
        for (int c = 1; c <= 9; c++) begin
            tick();
            done_at[c] = done1;
            busy_at[c] = busy1;
        end
        start1 = 1'b0;
        check("t6_held_done1", {31'h0, done_at[3]}, 32'h1);
        check("t6_held_idle",  {31'h0, busy_at[4]}, 32'h0);
        check("t6_held_rerun", {31'h0, busy_at[5]}, 32'h1);
        check("t6_held_done2", {31'h0, done_at[7]}, 32'h1);
        check("t6_held_nodup", {31'h0, done_at[6]}, 32'h0);
        check("t6_held_result", res1, 32'd15);
        tick(); tick(); tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_alu_mul_sequencer
